// File: rtl/clock_pkg.sv
// Shared definitions for the MimasV2 clock: mode encodings and the default board clock rate.
package clock_pkg;

  localparam int unsigned DEF_CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// 1 Hz prescaler: free-running 0..CLK_HZ-1 counter producing the seconds tick and the
// half-second blink square wave; i_load restarts the second from zero.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = clock_pkg::DEF_CLK_HZ,
  parameter int unsigned CNT_W  = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_tick_now,
  output logic o_tick_1hz,
  output logic o_blink
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_blink;
  logic             w_at_max;
  logic             w_at_half;

  assign w_at_max   = (r_cnt == CNT_W'(CLK_HZ - 1));
  assign w_at_half  = (r_cnt == CNT_W'(CLK_HZ / 2 - 1));
  // Decision-cycle tick for the enable logic; a reload swallows it.
  assign o_tick_now = w_at_max & ~i_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_blink <= 1'b1;
    end else begin
      r_cnt  <= (i_load || w_at_max) ? '0 : r_cnt + 1'b1;
      r_tick <= o_tick_now;
      if (!i_load && (w_at_max || w_at_half))
        r_blink <= ~r_blink;
    end
  end

  assign o_tick_1hz = r_tick;
  assign o_blink    = r_blink;

endmodule

// File: rtl/clock_time_controller.sv
// Sequences the seconds/minutes/hours counter enables and runs the button-driven
// time-set FSM (RUN -> SET_HR -> SET_MIN -> RUN) for the MimasV2 clock.
module clock_time_controller
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned CNT_W  = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_wrap,
  input  logic       min_wrap,
  output logic       sec_ena,
  output logic       sec_clr,
  output logic       min_ena,
  output logic       hr_ena,
  output logic       tick_1hz,
  output logic [1:0] mode,
  output logic       blink
);

  mode_e r_state;
  mode_e w_next;
  logic  r_start;
  logic  r_sec_ena, r_sec_clr, r_min_ena, r_hr_ena;
  logic  w_sec_ena, w_sec_clr, w_min_ena, w_hr_ena;
  logic  w_load;
  logic  w_tick_now;

  // Leaving SET_MIN restarts the second so the first one after setting is full length.
  assign w_load = (r_state == MODE_SET_MIN) && btn_mode;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .o_tick_now (w_tick_now),
    .o_tick_1hz (tick_1hz),
    .o_blink    (blink)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= MODE_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MODE_RUN:     if (btn_mode) w_next = MODE_SET_HR;
      MODE_SET_HR:  if (btn_mode) w_next = MODE_SET_MIN;
      MODE_SET_MIN: if (btn_mode) w_next = MODE_RUN;
      default:                    w_next = MODE_RUN;
    endcase
  end

  always_comb begin
    w_sec_ena = 1'b0;
    w_min_ena = 1'b0;
    w_hr_ena  = 1'b0;
    w_sec_clr = r_start;
    case (r_state)
      MODE_RUN: begin
        w_sec_ena = w_tick_now;
        w_min_ena = w_tick_now & sec_wrap;
        w_hr_ena  = w_tick_now & sec_wrap & min_wrap;
      end
      MODE_SET_HR:  w_hr_ena = btn_inc & ~btn_mode;
      MODE_SET_MIN: begin
        w_min_ena = btn_inc & ~btn_mode;
        w_sec_clr = r_start | btn_mode;
      end
      default: ;
    endcase
  end

  // r_start marks the first cycle after reset so the seconds counter is cleared then.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start   <= 1'b1;
      r_sec_ena <= 1'b0;
      r_sec_clr <= 1'b0;
      r_min_ena <= 1'b0;
      r_hr_ena  <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_sec_ena <= w_sec_ena;
      r_sec_clr <= w_sec_clr;
      r_min_ena <= w_min_ena;
      r_hr_ena  <= w_hr_ena;
    end
  end

  assign sec_ena = r_sec_ena;
  assign sec_clr = r_sec_clr;
  assign min_ena = r_min_ena;
  assign hr_ena  = r_hr_ena;
  assign mode    = r_state;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with CLK_HZ = 10; cycle k counts rising
// edges since the last reset release.
module tb_clock_time_controller;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, sec_wrap, min_wrap;
  logic       sec_ena, sec_clr, min_ena, hr_ena, tick_1hz, blink;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  clock_time_controller #(
    .CLK_HZ (10),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_wrap (sec_wrap),
    .min_wrap (min_wrap),
    .sec_ena  (sec_ena),
    .sec_clr  (sec_clr),
    .min_ena  (min_ena),
    .hr_ena   (hr_ena),
    .tick_1hz (tick_1hz),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 200 && k < n; i++) step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sec_ena"}, {31'd0, sec_ena}, 32'd0);
    check({tag, "_min_ena"}, {31'd0, min_ena}, 32'd0);
    check({tag, "_hr_ena"},  {31'd0, hr_ena},  32'd0);
  endtask

  initial begin
    int n_sec, n_tick, n_hr;
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; sec_wrap = 1'b0; min_wrap = 1'b0;
    step(); step(); step();
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_blink", {31'd0, blink}, 32'd1);
    check("rst_tick", {31'd0, tick_1hz}, 32'd0);
    check("rst_sec_clr", {31'd0, sec_clr}, 32'd0);
    check_quiet("rst");

    // 1: free run after reset
    reset = 1'b0; k = 0;
    for (int j = 1; j <= 35; j++) begin
      step();
      check("t1_sec_clr", {31'd0, sec_clr}, {31'd0, (j == 1)});
      check("t1_tick", {31'd0, tick_1hz}, {31'd0, (j % 10 == 0)});
      check("t1_sec_ena", {31'd0, sec_ena}, {31'd0, (j % 10 == 0)});
      check("t1_blink", {31'd0, blink}, {31'd0, ((j / 5) % 2 == 0)});
      check("t1_min_ena", {31'd0, min_ena}, 32'd0);
    end

    // 2: wrap cascades at a tick
    sec_wrap = 1'b1;
    run_to(40);
    check("t2_sec_ena", {31'd0, sec_ena}, 32'd1);
    check("t2_min_ena", {31'd0, min_ena}, 32'd1);
    check("t2_hr_ena", {31'd0, hr_ena}, 32'd0);
    step();
    check_quiet("t2_after");
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    check_quiet("t2_inc_run");
    check("t2_inc_mode", {30'd0, mode}, 32'd0);
    min_wrap = 1'b1;
    run_to(50);
    check("t2b_sec_ena", {31'd0, sec_ena}, 32'd1);
    check("t2b_min_ena", {31'd0, min_ena}, 32'd1);
    check("t2b_hr_ena", {31'd0, hr_ena}, 32'd1);
    sec_wrap = 1'b0; min_wrap = 1'b0;

    // 3: SET_HR, three increments
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("t3_mode", {30'd0, mode}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      btn_inc = 1'b1; step(); btn_inc = 1'b0;
      check("t3_hr_pulse", {31'd0, hr_ena}, 32'd1);
      step();
      check("t3_hr_low", {31'd0, hr_ena}, 32'd0);
    end
    n_sec = 0; n_tick = 0; n_hr = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      n_sec += int'(sec_ena); n_tick += int'(tick_1hz); n_hr += int'(hr_ena);
    end
    check("t3_no_sec_ena", n_sec, 0);
    check("t3_ticks", n_tick, 2);
    check("t3_no_hr", n_hr, 0);
    check("t3_mode_hold", {30'd0, mode}, 32'd1);

    // 4: SET_MIN, two increments with wraps high
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("t4_mode", {30'd0, mode}, 32'd2);
    min_wrap = 1'b1; sec_wrap = 1'b1;
    for (int j = 0; j < 2; j++) begin
      btn_inc = 1'b1; step(); btn_inc = 1'b0;
      check("t4_min_pulse", {31'd0, min_ena}, 32'd1);
      check("t4_hr_pulse", {31'd0, hr_ena}, 32'd0);
      step();
      check("t4_min_low", {31'd0, min_ena}, 32'd0);
      check("t4_hr_low", {31'd0, hr_ena}, 32'd0);
    end
    min_wrap = 1'b0; sec_wrap = 1'b0;

    // 5: exit to RUN, simultaneous buttons, second exit and reload
    btn_mode = 1'b1; step();
    check("t5_exit_mode", {30'd0, mode}, 32'd0);
    check("t5_exit_clr", {31'd0, sec_clr}, 32'd1);
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    check("t5_both_mode", {30'd0, mode}, 32'd1);
    check("t5_both_hr", {31'd0, hr_ena}, 32'd0);
    step();
    check("t5_mode2", {30'd0, mode}, 32'd2);
    check("t5_clr_low", {31'd0, sec_clr}, 32'd0);
    step(); btn_mode = 1'b0;
    check("t5_mode0", {30'd0, mode}, 32'd0);
    check("t5_clr", {31'd0, sec_clr}, 32'd1);
    check("t5_tick_supp", {31'd0, tick_1hz}, 32'd0);
    for (int j = 1; j <= 10; j++) begin
      step();
      check("t5_tick", {31'd0, tick_1hz}, {31'd0, (j == 10)});
      check("t5_sec_ena", {31'd0, sec_ena}, {31'd0, (j == 10)});
      check("t5_clr_once", {31'd0, sec_clr}, 32'd0);
    end

    // 6: reset during SET_MIN with prescaler at 7
    btn_mode = 1'b1; step(); step(); btn_mode = 1'b0;
    check("t6_mode", {30'd0, mode}, 32'd2);
    run_to(k + 5);
    reset = 1'b1; step();
    check("t6_rst_mode", {30'd0, mode}, 32'd0);
    check("t6_rst_tick", {31'd0, tick_1hz}, 32'd0);
    check("t6_rst_clr", {31'd0, sec_clr}, 32'd0);
    check("t6_rst_blink", {31'd0, blink}, 32'd1);
    check_quiet("t6_rst");
    reset = 1'b0; k = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      check("t6_tick", {31'd0, tick_1hz}, {31'd0, (j == 10)});
      check("t6_clr", {31'd0, sec_clr}, {31'd0, (j == 1)});
    end
    check("t6_mode_run", {30'd0, mode}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
